// File: rtl/bram_pkg.sv
// Shared BRAM definitions for the byte-wide reader and the byte packer (writer).
package bram_pkg;

  localparam int unsigned BRAM_ADDR_W = 13;
  localparam int unsigned BRAM_DATA_W = 32;
  localparam int unsigned PACK_IN_W   = 8;
  localparam int unsigned PACK_LANES  = BRAM_DATA_W / PACK_IN_W;

  // Lane index width; at least one bit so single-lane builds still elaborate.
  function automatic int unsigned lane_idx_w(input int unsigned lanes);
    return (lanes > 1) ? $clog2(lanes) : 1;
  endfunction

  localparam int unsigned PACK_LANE_W = lane_idx_w(PACK_LANES);

  typedef enum logic [1:0] {
    PK_IDLE = 2'd0,
    PK_FILL = 2'd1,
    PK_DONE = 2'd2
  } packer_state_e;

endpackage

// File: rtl/bram_byte_packer.sv
// Packs a valid/ready byte stream into BRAM words written to consecutive addresses.
// Optional macro BRAM_PACKER_BIG_ENDIAN_EN: first byte of each word lands in the top lane.
module bram_byte_packer
  import bram_pkg::*;
#(
  parameter int unsigned ADDRESS_WIDTH  = BRAM_ADDR_W,
  parameter int unsigned DATA_IN_WIDTH  = PACK_IN_W,
  parameter int unsigned DATA_OUT_WIDTH = BRAM_DATA_W,
  parameter int unsigned BASE_ADDR      = 0,
  parameter int unsigned DEPTH          = 2048
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic                      en_i,
  input  logic                      valid_i,
  output logic                      ready_o,
  input  logic [DATA_IN_WIDTH-1:0]  data_i,
  input  logic                      last_i,
  output logic                      finish_o,
  output logic [ADDRESS_WIDTH:0]    word_count_o,
  output logic [ADDRESS_WIDTH-1:0]  bram_addr,
  output logic                      bram_en,
  output logic                      bram_we,
  output logic [DATA_OUT_WIDTH-1:0] bram_data_in
);

  localparam int unsigned LANES  = DATA_OUT_WIDTH / DATA_IN_WIDTH;
  localparam int unsigned LANE_W = lane_idx_w(LANES);
  localparam int unsigned CNT_W  = ADDRESS_WIDTH + 1;

  packer_state_e             state_q;
  logic [LANE_W-1:0]         lane_q;
  logic [LANE_W-1:0]         lane_pos;
  logic [DATA_OUT_WIDTH-1:0] word_q;
  logic [DATA_OUT_WIDTH-1:0] word_d;
  logic [ADDRESS_WIDTH-1:0]  addr_q;
  logic [ADDRESS_WIDTH-1:0]  bram_addr_q;
  logic [DATA_OUT_WIDTH-1:0] bram_data_q;
  logic [CNT_W-1:0]          count_q;
  logic                      ready_q;
  logic                      finish_q;
  logic                      wr_q;
  logic                      accept;
  logic                      word_done;
  logic                      sess_end;

  // Lane placement and word/session completion for the byte offered this cycle.
  always_comb begin
`ifdef BRAM_PACKER_BIG_ENDIAN_EN
    lane_pos = LANE_W'(LANES - 1) - lane_q;
`else
    lane_pos = lane_q;
`endif
    word_d = word_q;
    word_d[32'(lane_pos) * DATA_IN_WIDTH +: DATA_IN_WIDTH] = data_i;
    accept    = (state_q == PK_FILL) && en_i && valid_i;
    word_done = accept && (last_i || (lane_q == LANE_W'(LANES - 1)));
    sess_end  = word_done && (last_i || (count_q == CNT_W'(DEPTH - 1)));
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= PK_IDLE;
      lane_q      <= '0;
      word_q      <= '0;
      addr_q      <= '0;
      count_q     <= '0;
      bram_addr_q <= '0;
      bram_data_q <= '0;
      ready_q     <= 1'b0;
      finish_q    <= 1'b0;
      wr_q        <= 1'b0;
    end else begin
      wr_q     <= 1'b0;
      finish_q <= 1'b0;
      if (!en_i) begin
        // Abort: any partially packed word is dropped without a write.
        state_q <= PK_IDLE;
        ready_q <= 1'b0;
        lane_q  <= '0;
        word_q  <= '0;
      end else begin
        case (state_q)
          PK_IDLE: begin
            state_q <= PK_FILL;
            ready_q <= 1'b1;
            lane_q  <= '0;
            word_q  <= '0;
            addr_q  <= ADDRESS_WIDTH'(BASE_ADDR);
            count_q <= '0;
          end
          PK_FILL: begin
            if (word_done) begin
              wr_q        <= 1'b1;
              bram_addr_q <= addr_q;
              bram_data_q <= word_d;
              addr_q      <= addr_q + ADDRESS_WIDTH'(1);
              count_q     <= count_q + CNT_W'(1);
              lane_q      <= '0;
              word_q      <= '0;
              if (sess_end) begin
                finish_q <= 1'b1;
                state_q  <= PK_DONE;
                ready_q  <= 1'b0;
              end
            end else if (accept) begin
              lane_q <= lane_q + LANE_W'(1);
              word_q <= word_d;
            end
          end
          PK_DONE: begin
            ready_q <= 1'b0;
          end
          default: begin
            state_q <= PK_IDLE;
            ready_q <= 1'b0;
          end
        endcase
      end
    end
  end

  assign ready_o      = ready_q;
  assign finish_o     = finish_q;
  assign word_count_o = count_q;
  assign bram_addr    = bram_addr_q;
  assign bram_en      = wr_q;
  assign bram_we      = wr_q;
  assign bram_data_in = bram_data_q;

endmodule

// File: tb/tb_bram_byte_packer.sv
// Randomized and directed stimulus for bram_byte_packer, checked against a queue-based model.
module tb_bram_byte_packer;

  localparam int unsigned AW    = 13;
  localparam int unsigned DW    = 32;
  localparam int unsigned IW    = 8;
  localparam int unsigned LANES = DW / IW;
  localparam int unsigned BASE  = 8;
  localparam int unsigned DEP   = 3;

  logic          clk;
  logic          rst;
  logic          en;
  logic          valid;
  logic [IW-1:0] data;
  logic          last;
  logic          ready;
  logic          finish;
  logic [AW:0]   wcount;
  logic [AW-1:0] baddr;
  logic          ben;
  logic          bwe;
  logic [DW-1:0] bdata;

  int n_cmp = 0;
  int n_bad = 0;

  bram_byte_packer #(
    .ADDRESS_WIDTH (AW),
    .DATA_IN_WIDTH (IW),
    .DATA_OUT_WIDTH(DW),
    .BASE_ADDR     (BASE),
    .DEPTH         (DEP)
  ) dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .en_i        (en),
    .valid_i     (valid),
    .ready_o     (ready),
    .data_i      (data),
    .last_i      (last),
    .finish_o    (finish),
    .word_count_o(wcount),
    .bram_addr   (baddr),
    .bram_en     (ben),
    .bram_we     (bwe),
    .bram_data_in(bdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: session mode 0=idle 1=filling 2=finished, bytes of the open word in a queue.
  int            m_mode = 0;
  logic [IW-1:0] pend[$];
  logic          m_ready, m_wr, m_fin;
  logic [AW-1:0] m_addr;
  logic [DW-1:0] m_data;
  int            m_words;

  logic [AW-1:0] log_addr[$];
  logic [DW-1:0] log_data[$];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s @%0t: got %0h expected %0h", tag, $time, got, exp);
    end
  endtask

  function automatic logic [DW-1:0] build_word();
    logic [DW-1:0] w = '0;
    for (int i = 0; i < pend.size(); i++) begin
`ifdef BRAM_PACKER_BIG_ENDIAN_EN
      w[(LANES - 1 - i) * IW +: IW] = pend[i];
`else
      w[i * IW +: IW] = pend[i];
`endif
    end
    return w;
  endfunction

  task automatic model_step(input logic r, input logic e, input logic v,
                            input logic [IW-1:0] d, input logic l);
    m_wr  = 1'b0;
    m_fin = 1'b0;
    if (r) begin
      m_mode = 0; m_ready = 1'b0; m_addr = '0; m_data = '0; m_words = 0;
      pend.delete();
    end else if (!e) begin
      m_mode = 0; m_ready = 1'b0;
      pend.delete();
    end else if (m_mode == 0) begin
      m_mode = 1; m_ready = 1'b1; m_words = 0;
      pend.delete();
    end else if (m_mode == 1 && v) begin
      pend.push_back(d);
      if (pend.size() == LANES || l) begin
        m_wr   = 1'b1;
        m_data = build_word();
        m_addr = AW'(BASE + m_words);
        m_words++;
        pend.delete();
        if (l || m_words == DEP) begin
          m_fin = 1'b1; m_mode = 2; m_ready = 1'b0;
        end
      end
    end
  endtask

  task automatic cyc(input logic r, input logic e, input logic v,
                     input logic [IW-1:0] d, input logic l);
    rst = r; en = e; valid = v; data = d; last = l;
    @(posedge clk);
    model_step(r, e, v, d, l);
    #1;
    check("ready",  64'(ready),  64'(m_ready));
    check("bram_en", 64'(ben),   64'(m_wr));
    check("bram_we", 64'(bwe),   64'(m_wr));
    check("finish", 64'(finish), 64'(m_fin));
    check("count",  64'(wcount), 64'(m_words));
    check("addr",   64'(baddr),  64'(m_addr));
    check("data",   64'(bdata),  64'(m_data));
    if (bwe) begin
      log_addr.push_back(baddr);
      log_data.push_back(bdata);
    end
  endtask

  task automatic send(input logic [IW-1:0] b, input logic l);
    cyc(1'b0, 1'b1, 1'b1, b, l);
  endtask

  task automatic clear_log();
    log_addr.delete();
    log_data.delete();
  endtask

  logic [DW-1:0] e0, e1;

  initial begin
    rst = 1'b1; en = 1'b0; valid = 1'b0; data = '0; last = 1'b0;
    m_ready = 1'b0; m_addr = '0; m_data = '0; m_words = 0;
    cyc(1'b1, 1'b0, 1'b0, 8'h00, 1'b0);
    cyc(1'b1, 1'b1, 1'b1, 8'h5A, 1'b1);
    cyc(1'b0, 1'b0, 1'b0, 8'h00, 1'b0);

    // Two full words, last on the 8th byte.
    clear_log();
    cyc(1'b0, 1'b1, 1'b0, 8'h00, 1'b0);
    for (int i = 1; i <= 8; i++) send(IW'(i * 'h11), i == 8);
`ifdef BRAM_PACKER_BIG_ENDIAN_EN
    e0 = 32'h11223344; e1 = 32'h55667788;
`else
    e0 = 32'h44332211; e1 = 32'h88776655;
`endif
    check("t1_nwr", 64'(log_data.size()), 64'd2);
    if (log_data.size() == 2) begin
      check("t1_d0", 64'(log_data[0]), 64'(e0));
      check("t1_d1", 64'(log_data[1]), 64'(e1));
      check("t1_a0", 64'(log_addr[0]), 64'(BASE));
      check("t1_a1", 64'(log_addr[1]), 64'(BASE + 1));
    end
    check("t1_cnt", 64'(wcount), 64'd2);
    for (int i = 0; i < 3; i++) cyc(1'b0, 1'b1, 1'b1, 8'hEE, 1'b0);
    cyc(1'b0, 1'b0, 1'b0, 8'h00, 1'b0);

    // Short final word.
    clear_log();
    cyc(1'b0, 1'b1, 1'b0, 8'h00, 1'b0);
    send(8'hAA, 1'b0); send(8'hBB, 1'b0); send(8'hCC, 1'b1);
`ifdef BRAM_PACKER_BIG_ENDIAN_EN
    e0 = 32'hAABBCC00;
`else
    e0 = 32'h00CCBBAA;
`endif
    check("t2_nwr", 64'(log_data.size()), 64'd1);
    if (log_data.size() == 1) begin
      check("t2_d0", 64'(log_data[0]), 64'(e0));
      check("t2_a0", 64'(log_addr[0]), 64'(BASE));
    end
    for (int i = 0; i < 4; i++) cyc(1'b0, 1'b1, 1'b1, 8'h99, 1'b1);
    cyc(1'b0, 1'b0, 1'b0, 8'h00, 1'b0);

    // Region fills at DEP words with no last; the following byte is refused.
    clear_log();
    cyc(1'b0, 1'b1, 1'b0, 8'h00, 1'b0);
    for (int i = 0; i < DEP * LANES + 2; i++) send(IW'($urandom), 1'b0);
    check("t3_nwr", 64'(log_data.size()), 64'(DEP));
    if (log_addr.size() == DEP) check("t3_alast", 64'(log_addr[DEP-1]), 64'(BASE + DEP - 1));
    cyc(1'b0, 1'b0, 1'b1, 8'h00, 1'b0);

    // Abort mid-word, then restart from BASE.
    clear_log();
    cyc(1'b0, 1'b1, 1'b0, 8'h00, 1'b0);
    for (int i = 0; i < LANES + 2; i++) send(IW'($urandom), 1'b0);
    cyc(1'b0, 1'b0, 1'b1, 8'h42, 1'b1);
    cyc(1'b0, 1'b0, 1'b0, 8'h00, 1'b0);
    check("t4_nwr", 64'(log_data.size()), 64'd1);
    cyc(1'b0, 1'b1, 1'b0, 8'h00, 1'b0);
    check("t4_cnt0", 64'(wcount), 64'd0);
    clear_log();
    for (int i = 0; i < LANES; i++) send(IW'($urandom), 1'b0);
    if (log_addr.size() == 1) check("t4_restart", 64'(log_addr[0]), 64'(BASE));
    else check("t4_restart_n", 64'(log_addr.size()), 64'd1);

    // Reset mid-fill.
    send(8'h12, 1'b0); send(8'h34, 1'b0);
    cyc(1'b1, 1'b1, 1'b1, 8'h56, 1'b1);
    check("t5_rst_cnt", 64'(wcount), 64'd0);
    check("t5_rst_we", 64'(bwe), 64'd0);
    cyc(1'b0, 1'b0, 1'b0, 8'h00, 1'b0);

    // Lane order: one full word then a single-byte final word.
    clear_log();
    cyc(1'b0, 1'b1, 1'b0, 8'h00, 1'b0);
    for (int i = 1; i <= 5; i++) send(IW'(i * 'h11), i == 5);
`ifdef BRAM_PACKER_BIG_ENDIAN_EN
    e0 = 32'h11223344; e1 = 32'h55000000;
`else
    e0 = 32'h44332211; e1 = 32'h00000055;
`endif
    check("t6_nwr", 64'(log_data.size()), 64'd2);
    if (log_data.size() == 2) begin
      check("t6_d0", 64'(log_data[0]), 64'(e0));
      check("t6_d1", 64'(log_data[1]), 64'(e1));
    end
    cyc(1'b0, 1'b0, 1'b0, 8'h00, 1'b0);

    // Random traffic.
    for (int i = 0; i < 1500; i++) begin
      cyc(($urandom_range(0, 199) == 0),
          ($urandom_range(0, 39) != 0),
          ($urandom_range(0, 9) < 7),
          IW'($urandom),
          ($urandom_range(0, 9) == 0));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
